// File: rtl/coord_pkg.sv
// Shared types and constants for the coordinate frame parser and the
// serial parsers built alongside it.
package coord_pkg;

  localparam int         COORD_W       = 12;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    XH   = 3'd1,
    XL   = 3'd2,
    YH   = 3'd3,
    YL   = 3'd4,
    CHK  = 3'd5
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // High bytes carry only coordinate bits [11:8]; anything in the top nibble is corrupt.
  function automatic logic hi_nibble_bad(input logic [7:0] b);
    return b[7:4] != 4'h0;
  endfunction

endpackage

// File: rtl/coord_timeout.sv
// Inter-byte idle timer: up-counter with clear, load and enable, flagging
// expiry when it reaches TIMEOUT_CYCLES-1. Clear wins over load and enable.
module coord_timeout #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count idle cycles; owner clears on activity and stops counting when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == LP_TERM);

endmodule

// File: rtl/coord_frame_ctrl.sv
// Coordinate frame parser between the UART receiver and the six-digit
// coordinate display. Frames are SYNC, XH, XL, YH, YL[, CHK]; x/y only
// change on a complete valid frame.
// Build option: define COORD_CHECKSUM_EN to include the CHK byte and its
// XOR check; without it the frame ends at YL.
//
// state | meaning
// IDLE  | waiting for SYNC_BYTE, other bytes ignored
// XH    | expecting X bits [11:8] (high nibble must be 0)
// XL    | expecting X bits [7:0]
// YH    | expecting Y bits [11:8] (high nibble must be 0)
// YL    | expecting Y bits [7:0]; frame ends here without checksum
// CHK   | expecting XOR of the four payload bytes
module coord_frame_ctrl
  import coord_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_ok,
  output logic               frame_err,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  state_t       r_state;
  state_t       w_next;
  logic         w_accept;
  logic         w_error;
  logic         w_expired;
  logic         w_tmo_clr;
  logic         w_tmo_en;

  logic [11:0]  r_x_sh;
  logic [3:0]   r_y_hi;
  coord_t       w_load_val;
  coord_t       r_coord;
  logic         r_ok;
  logic         r_err;
  logic         r_busy;
  logic [7:0]   r_err_cnt;

`ifdef COORD_CHECKSUM_EN
  logic [7:0]   r_y_lo;
  logic [7:0]   r_chk;
  assign w_load_val = {r_x_sh, r_y_hi, r_y_lo};
`else
  // Frame ends on YL, so its byte goes straight to the display registers.
  assign w_load_val = {r_x_sh, r_y_hi, rx_data};
`endif

  // Timer runs only inside a frame and restarts on every byte and on return to IDLE.
  assign w_tmo_clr = rx_valid | (w_next == IDLE);
  assign w_tmo_en  = (r_state != IDLE);

  coord_timeout #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (w_tmo_clr),
    .i_en       (w_tmo_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_expired  (w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state plus accept/error decisions; a byte on the expiry cycle beats the timeout.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_error  = 1'b0;
    if (rx_valid) begin
      case (r_state)
        IDLE: if (rx_data == SYNC_BYTE) w_next = XH;
        XH: begin
          if (hi_nibble_bad(rx_data)) begin
            w_next  = IDLE;
            w_error = 1'b1;
          end else begin
            w_next = XL;
          end
        end
        XL: w_next = YH;
        YH: begin
          if (hi_nibble_bad(rx_data)) begin
            w_next  = IDLE;
            w_error = 1'b1;
          end else begin
            w_next = YL;
          end
        end
`ifdef COORD_CHECKSUM_EN
        YL: w_next = CHK;
        CHK: begin
          w_next = IDLE;
          if (rx_data == r_chk) w_accept = 1'b1;
          else                  w_error  = 1'b1;
        end
`else
        YL: begin
          w_next   = IDLE;
          w_accept = 1'b1;
        end
`endif
        default: w_next = IDLE;
      endcase
    end else if ((r_state != IDLE) && w_expired) begin
      w_next  = IDLE;
      w_error = 1'b1;
    end
  end

  // Payload capture into shadow registers; display is untouched until accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_sh <= '0;
      r_y_hi <= '0;
    end else if (rx_valid) begin
      case (r_state)
        XH:      r_x_sh[11:8] <= rx_data[3:0];
        XL:      r_x_sh[7:0]  <= rx_data;
        YH:      r_y_hi       <= rx_data[3:0];
        default: ;
      endcase
    end
  end

`ifdef COORD_CHECKSUM_EN
  // Low Y byte and running XOR of the four payload bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_lo <= '0;
      r_chk  <= '0;
    end else begin
      if (rx_valid && (r_state == YL)) r_y_lo <= rx_data;
      if (r_state == IDLE)                       r_chk <= '0;
      else if (rx_valid && (r_state != CHK))     r_chk <= r_chk ^ rx_data;
    end
  end
`endif

  // Registered outputs: display load, status pulses, busy and saturating error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_coord   <= '0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_ok   <= w_accept;
      r_err  <= w_error;
      r_busy <= (w_next != IDLE);
      if (w_accept) r_coord <= w_load_val;
      if (w_error && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign x         = r_coord.x;
  assign y         = r_coord.y;
  assign frame_ok  = r_ok;
  assign frame_err = r_err;
  assign busy      = r_busy;
  assign err_cnt   = r_err_cnt;

endmodule
